// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
//   parity_t    : line parity mode (none / odd / even)
//   rx_state_t  : receiver frame state
//   clk_per_bit : system clocks per bit from clock and line rate in MHz / Mbit/s
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int clk_per_bit(real sysclk, real baud);
    return int'(sysclk / baud);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level input.
// Both flops reset to 1 so an idle-high serial line shows no edge on reset release.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_bit_sampler.sv
// Bit timer with 3-point majority-vote mid-bit sampling.
// The timer runs 0..CPB-1 inside each bit; the cycle in which the start edge is
// seen is position 0. Samples are taken at MID-1, MID and MID+1 and the bit value
// is resolved (bit_done strobe) at MID+1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : start edge accepted this cycle (restarts the timer)
//   run        : a frame is in progress
//   rx_s       : synchronised serial line
//   bit_done   : one-cycle strobe at MID+1 of each bit
//   bit_val    : majority value, valid with bit_done
module uart_bit_sampler #(
  parameter int CPB = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  input  logic rx_s,
  output logic bit_done,
  output logic bit_val
);

  localparam int TW  = $clog2(CPB);
  localparam int MID = CPB / 2;

  logic [TW-1:0] tmr;
  logic          s0, s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
      s0  <= 1'b0;
      s1  <= 1'b0;
    end else begin
      if (start)
        tmr <= TW'(1);
      else if (run)
        tmr <= (tmr == TW'(CPB - 1)) ? '0 : tmr + TW'(1);
      else
        tmr <= '0;
      if (run && tmr == TW'(MID - 1)) s0 <= rx_s;
      if (run && tmr == TW'(MID))     s1 <= rx_s;
    end
  end

  assign bit_done = run && (tmr == TW'(MID + 1));
  assign bit_val  = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// majority-vote sampling, per-frame parity/framing error flags and an idle
// block-timeout pulse.
// Optional feature macro: UART_RX_BREAK_DET_EN (all-zero frame reported as break).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rx            : raw serial line, idle high, asynchronous
//   rx_bsy        : frame in progress
//   data_valid    : one-cycle pulse, data_out/parity_err/frame_err valid
//   data_out      : received payload, LSB first on the line
//   parity_err    : parity mismatch of the reported frame
//   frame_err     : a stop bit of the reported frame was sampled low
//   block_timeout : pulse after TIMEOUT_BITS idle bit-times following a frame
//   break_det     : break pulse (0 unless UART_RX_BREAK_DET_EN)
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a falling edge on the line
// ST_START  | sampling start bit, false start returns idle
// ST_DATA   | shifting in DATA_BITS payload bits
// ST_PARITY | sampling and checking the parity bit
// ST_STOP   | sampling STOP_BITS stop bits, then report
module uart_rx_param
  import uart_pkg::*;
#(
  parameter real SYSCLOCK     = 27.0,
  parameter real BAUDRATE     = 1.0,
  parameter int  DATA_BITS    = 8,
  parameter int  PARITY       = 0,
  parameter int  STOP_BITS    = 1,
  parameter int  TIMEOUT_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 rx_bsy,
  output logic                 data_valid,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 block_timeout,
  output logic                 break_det
);

  localparam int      CPB      = clk_per_bit(SYSCLOCK, BAUDRATE);
  localparam int      TC       = TIMEOUT_BITS * CPB;
  localparam int      IW       = $clog2(TC + 1);
  localparam parity_t PAR_MODE = parity_t'(PARITY);

  rx_state_t            state, state_nxt;
  logic                 rx_sync, rx_hold, start_edge;
  logic                 bit_done, bit_val;
  logic [3:0]           bit_cnt;
  logic                 last_data, last_stop, frame_done, report, is_break;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend, frm_pend, exp_par;
  logic                 armed;
  logic [IW-1:0]        idle_cnt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_hold <= 1'b1;
    else        rx_hold <= rx_sync;
  end

  // A falling edge needs a high hold sample, so after a break the line must
  // return high before another frame can start.
  assign start_edge = (state == ST_IDLE) && rx_hold && !rx_sync;

  uart_bit_sampler #(.CPB(CPB)) u_sampler (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_edge),
    .run      (state != ST_IDLE),
    .rx_s     (rx_sync),
    .bit_done (bit_done),
    .bit_val  (bit_val)
  );

  assign last_data  = (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop  = (bit_cnt == 4'(STOP_BITS - 1));
  assign frame_done = (state == ST_STOP) && bit_done && last_stop;
  assign report     = frame_done && !is_break;
  assign exp_par    = (^shreg) ^ (PAR_MODE == PAR_ODD);
  assign rx_bsy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start_edge) state_nxt = ST_START;
      ST_START:  if (bit_done) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (bit_done && last_data)
                   state_nxt = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_done) state_nxt = ST_STOP;
      ST_STOP:   if (frame_done) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_pend   <= 1'b0;
      frm_pend   <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_edge) begin
        bit_cnt  <= '0;
        par_pend <= 1'b0;
        frm_pend <= 1'b0;
      end else if (bit_done) begin
        case (state)
          ST_START:  bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            bit_cnt <= last_data ? '0 : bit_cnt + 4'd1;
          end
          ST_PARITY: par_pend <= (bit_val != exp_par);
          ST_STOP: begin
            if (!bit_val) frm_pend <= 1'b1;
            bit_cnt <= last_stop ? '0 : bit_cnt + 4'd1;
          end
          default: ;
        endcase
      end
      if (report) begin
        data_out   <= shreg;
        parity_err <= par_pend;
        frame_err  <= frm_pend | ~bit_val;
        data_valid <= 1'b1;
      end
    end
  end

`ifdef UART_RX_BREAK_DET_EN
  logic all_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_zero  <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (start_edge)             all_zero <= 1'b1;
      else if (bit_done && bit_val) all_zero <= 1'b0;
      break_det <= frame_done && is_break;
    end
  end

  assign is_break = all_zero && !bit_val;
`else
  assign is_break  = 1'b0;
  assign break_det = 1'b0;
`endif

  // A start edge in the terminal-count cycle wins: it is checked first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed         <= 1'b0;
      idle_cnt      <= '0;
      block_timeout <= 1'b0;
    end else begin
      block_timeout <= 1'b0;
      if (start_edge) begin
        armed    <= 1'b0;
        idle_cnt <= '0;
      end else if (report) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if (armed && state == ST_IDLE) begin
        if (idle_cnt == IW'(TC - 1)) begin
          block_timeout <= 1'b1;
          armed         <= 1'b0;
          idle_cnt      <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
      end
    end
  end

endmodule
